pipeline_hazard_ctrl: RTL and testbench

Central hazard and stall sequencer for the 5-stage core. It drives the stall and flush enables of the fetch, decode, execute and memory pipeline registers, and selects operand forwarding for the execute stage. It sequences data-memory/cache-miss waits and ECALL drain-to-halt. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/core_pkg.sv | 23 ++
 rtl/hazard_forward_unit.sv | 52 +++++
 rtl/pipeline_hazard_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the 5-stage core's hazard logic:
//   - t_hz_state : hazard sequencer states
//   - FWD_*      : execute-stage operand forward selects
//   - LOAD_SRC_ENC : result_src encoding that marks a load
// ----------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALT     = 2'd3
  } t_hz_state;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] LOAD_SRC_ENC = 3'b001;

endpackage

// File: rtl/hazard_forward_unit.sv
// ----------------------------------------------------------------------------
// hazard_forward_unit
// Combinational operand-forward select for the execute stage. Each source
// register is resolved independently; a memory-stage producer is younger
// than a writeback-stage producer and therefore wins.
// Ports:
//   i_rs1_addr_e / i_rs2_addr_e : execute-stage source registers
//   i_rd_addr_m, i_reg_we_m     : memory-stage destination / write enable
//   i_rd_addr_w, i_reg_we_w     : writeback-stage destination / write enable
//   o_fwd_rs1_e / o_fwd_rs2_e   : FWD_RF, FWD_WB or FWD_MEM
// ----------------------------------------------------------------------------
module hazard_forward_unit
  import core_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_e,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_e,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_m,
  input  logic                  i_reg_we_m,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_w,
  input  logic                  i_reg_we_w,
  output logic [1:0]            o_fwd_rs1_e,
  output logic [1:0]            o_fwd_rs2_e
);

  // x0 is hard-wired to zero, so a write to it is never a valid producer.
  function automatic logic [1:0] fwd_select(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  we_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  we_w
  );
    logic [1:0] sel;
    if (we_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Forward selects for both execute-stage operands.
  always_comb begin
    o_fwd_rs1_e = fwd_select(i_rs1_addr_e, i_rd_addr_m, i_reg_we_m, i_rd_addr_w, i_reg_we_w);
    o_fwd_rs2_e = fwd_select(i_rs2_addr_e, i_rd_addr_m, i_reg_we_m, i_rd_addr_w, i_reg_we_w);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central hazard and stall sequencer for the 5-stage core.
//   - Stall/flush enables for the F/D/E/M pipeline registers (combinational
//     from current state and inputs).
//   - Data-memory wait sequencing (RUN <-> MEM_WAIT).
//   - ECALL drain-to-halt (RUN -> DRAIN for two cycles -> HALT).
//   - Execute-stage forward selects (via hazard_forward_unit).
//   - Saturating stall-cycle counter.
// Ports:
//   i_clk, i_arst            : clock, async active-high reset
//   i_rs*_addr_d/e, i_rd_*   : register addresses per stage
//   i_result_src_e           : execute result source (load detection)
//   i_branch_taken_e         : redirect resolved in execute
//   i_mem_access_m/i_mem_ready : memory-stage access and completion
//   i_ecall_m, i_a0_lsb_m    : ECALL in memory stage and its exit bit
//   o_stall_f/d/e/m          : hold pipeline registers
//   o_flush_d/e              : bubble decode / execute
//   o_fwd_rs1_e/o_fwd_rs2_e  : forward selects
//   o_halt, o_exit_code      : halted flag and latched exit bit
//   o_stall_cnt              : stall-cycle counter
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import core_pkg::*;
#(
  parameter int         REG_ADDR_W = 5,
  parameter int         CNT_W      = 32,
  parameter logic [2:0] LOAD_SRC   = LOAD_SRC_ENC
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_d,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_d,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_e,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_e,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_e,
  input  logic [2:0]            i_result_src_e,
  input  logic                  i_branch_taken_e,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_m,
  input  logic                  i_reg_we_m,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_w,
  input  logic                  i_reg_we_w,
  input  logic                  i_mem_access_m,
  input  logic                  i_mem_ready,
  input  logic                  i_ecall_m,
  input  logic                  i_a0_lsb_m,
  output logic                  o_stall_f,
  output logic                  o_stall_d,
  output logic                  o_stall_e,
  output logic                  o_stall_m,
  output logic                  o_flush_d,
  output logic                  o_flush_e,
  output logic [1:0]            o_fwd_rs1_e,
  output logic [1:0]            o_fwd_rs2_e,
  output logic                  o_halt,
  output logic                  o_exit_code,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  t_hz_state        state_q, state_d;
  logic             drain_q, drain_d;
  logic             exit_code_q, exit_code_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             mem_stall;
  logic             load_use;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e;

  // Load-use: the load result is not available until after M, so a
  // dependent instruction in decode must wait one cycle.
  always_comb begin
    load_use = (i_result_src_e == LOAD_SRC) && (i_rd_addr_e != '0) &&
               ((i_rd_addr_e == i_rs1_addr_d) || (i_rd_addr_e == i_rs2_addr_d));
  end

  // Next-state, stall/flush outputs and counter update.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    exit_code_d = exit_code_q;
    stall_cnt_d = stall_cnt_q;
    mem_stall   = 1'b0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;

    case (state_q)
      RUN, MEM_WAIT: begin
        // In RUN a stall needs a fresh access; in MEM_WAIT the access is
        // already outstanding so only ready matters.
        if (state_q == RUN) begin
          mem_stall = i_mem_access_m & ~i_mem_ready;
        end else begin
          mem_stall = ~i_mem_ready;
        end

        if (mem_stall) begin
          // Whole pipe freezes; branch, load-use and ECALL wait.
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          state_d = MEM_WAIT;
        end else begin
          // A taken branch discards the dependent instruction, so no
          // load-use stall is needed when both fire.
          flush_d = i_branch_taken_e;
          flush_e = i_branch_taken_e | load_use;
          stall_f = load_use & ~i_branch_taken_e;
          stall_d = load_use & ~i_branch_taken_e;
          if ((state_q == RUN) && i_ecall_m) begin
            state_d     = DRAIN;
            drain_d     = 1'b0;
            exit_code_d = i_a0_lsb_m;
          end else begin
            state_d = RUN;
          end
        end
      end

      DRAIN: begin
        // Front end held while M and W retire what is ahead of the ECALL.
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
        if (drain_q) begin
          state_d = HALT;
        end else begin
          drain_d = 1'b1;
        end
      end

      HALT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Saturating count of front-end stall cycles; halted time is excluded.
    if (stall_f && (state_q != HALT) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q     <= RUN;
      drain_q     <= 1'b0;
      exit_code_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      exit_code_q <= exit_code_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  hazard_forward_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd (
    .i_rs1_addr_e (i_rs1_addr_e),
    .i_rs2_addr_e (i_rs2_addr_e),
    .i_rd_addr_m  (i_rd_addr_m),
    .i_reg_we_m   (i_reg_we_m),
    .i_rd_addr_w  (i_rd_addr_w),
    .i_reg_we_w   (i_reg_we_w),
    .o_fwd_rs1_e  (o_fwd_rs1_e),
    .o_fwd_rs2_e  (o_fwd_rs2_e)
  );

  assign o_stall_f   = stall_f;
  assign o_stall_d   = stall_d;
  assign o_stall_e   = stall_e;
  assign o_stall_m   = stall_m;
  assign o_flush_d   = flush_d;
  assign o_flush_e   = flush_e;
  assign o_halt      = (state_q == HALT);
  assign o_exit_code = exit_code_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int RW    = 5;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          i_clk;
  logic          i_arst;
  logic [RW-1:0] i_rs1_addr_d, i_rs2_addr_d, i_rs1_addr_e, i_rs2_addr_e, i_rd_addr_e;
  logic [2:0]    i_result_src_e;
  logic          i_branch_taken_e;
  logic [RW-1:0] i_rd_addr_m, i_rd_addr_w;
  logic          i_reg_we_m, i_reg_we_w;
  logic          i_mem_access_m, i_mem_ready, i_ecall_m, i_a0_lsb_m;
  logic          o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_flush_d, o_flush_e;
  logic [1:0]    o_fwd_rs1_e, o_fwd_rs2_e;
  logic          o_halt, o_exit_code;
  logic [CW-1:0] o_stall_cnt;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .LOAD_SRC(3'b001)) dut (
    .i_clk(i_clk), .i_arst(i_arst),
    .i_rs1_addr_d(i_rs1_addr_d), .i_rs2_addr_d(i_rs2_addr_d),
    .i_rs1_addr_e(i_rs1_addr_e), .i_rs2_addr_e(i_rs2_addr_e),
    .i_rd_addr_e(i_rd_addr_e), .i_result_src_e(i_result_src_e),
    .i_branch_taken_e(i_branch_taken_e),
    .i_rd_addr_m(i_rd_addr_m), .i_reg_we_m(i_reg_we_m),
    .i_rd_addr_w(i_rd_addr_w), .i_reg_we_w(i_reg_we_w),
    .i_mem_access_m(i_mem_access_m), .i_mem_ready(i_mem_ready),
    .i_ecall_m(i_ecall_m), .i_a0_lsb_m(i_a0_lsb_m),
    .o_stall_f(o_stall_f), .o_stall_d(o_stall_d), .o_stall_e(o_stall_e), .o_stall_m(o_stall_m),
    .o_flush_d(o_flush_d), .o_flush_e(o_flush_e),
    .o_fwd_rs1_e(o_fwd_rs1_e), .o_fwd_rs2_e(o_fwd_rs2_e),
    .o_halt(o_halt), .o_exit_code(o_exit_code), .o_stall_cnt(o_stall_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic m_waiting;   // outstanding memory access not yet completed
  int   m_drain;     // remaining drain cycles (0 = not draining)
  logic m_halted;
  logic m_exit;
  int   m_cnt;
  logic e_sf, e_sd, e_se, e_sm, e_fd, e_fe;
  logic [1:0] e_f1, e_f2;

  task automatic m_reset();
    m_waiting = 1'b0; m_drain = 0; m_halted = 1'b0; m_exit = 1'b0; m_cnt = 0;
  endtask

  function automatic logic [1:0] m_fwd(input logic [RW-1:0] rs);
    if (i_reg_we_m && i_rd_addr_m != 0 && i_rd_addr_m == rs) return 2'b10;
    if (i_reg_we_w && i_rd_addr_w != 0 && i_rd_addr_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_memstall();
    if (m_halted || m_drain > 0) return 1'b0;
    return m_waiting ? ~i_mem_ready : (i_mem_access_m & ~i_mem_ready);
  endfunction

  task automatic m_eval();
    logic lu;
    lu = (i_result_src_e == 3'b001) && (i_rd_addr_e != 0) &&
         (i_rd_addr_e == i_rs1_addr_d || i_rd_addr_e == i_rs2_addr_d);
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe} = 6'b0;
    if (m_halted || m_memstall()) {e_sf, e_sd, e_se, e_sm} = 4'b1111;
    else if (m_drain > 0) begin e_sf = 1; e_sd = 1; e_fe = 1; end
    else if (i_branch_taken_e) begin e_fd = 1; e_fe = 1; end
    else if (lu) begin e_sf = 1; e_sd = 1; e_fe = 1; end
    e_f1 = m_fwd(i_rs1_addr_e);
    e_f2 = m_fwd(i_rs2_addr_e);
  endtask

  task automatic m_update();
    logic ms;
    ms = m_memstall();
    if (!m_halted && e_sf && m_cnt < CMAX) m_cnt++;
    if (m_halted) begin end
    else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) m_halted = 1'b1;
    end else if (m_waiting) begin
      if (i_mem_ready) m_waiting = 1'b0;
    end else if (ms) m_waiting = 1'b1;
    else if (i_ecall_m) begin m_drain = 2; m_exit = i_a0_lsb_m; end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".stall_f"}, 32'(o_stall_f), 32'(e_sf));
    chk({tag, ".stall_d"}, 32'(o_stall_d), 32'(e_sd));
    chk({tag, ".stall_e"}, 32'(o_stall_e), 32'(e_se));
    chk({tag, ".stall_m"}, 32'(o_stall_m), 32'(e_sm));
    chk({tag, ".flush_d"}, 32'(o_flush_d), 32'(e_fd));
    chk({tag, ".flush_e"}, 32'(o_flush_e), 32'(e_fe));
    chk({tag, ".fwd1"},    32'(o_fwd_rs1_e), 32'(e_f1));
    chk({tag, ".fwd2"},    32'(o_fwd_rs2_e), 32'(e_f2));
    chk({tag, ".halt"},    32'(o_halt), 32'(m_halted));
    chk({tag, ".exit"},    32'(o_exit_code), 32'(m_exit));
    chk({tag, ".cnt"},     32'(o_stall_cnt), 32'(m_cnt));
  endtask

  // One cycle: inputs already driven; check at negedge, advance model at posedge.
  task automatic step(input string tag);
    @(negedge i_clk);
    m_eval();
    check_all(tag);
    @(posedge i_clk);
    m_update();
    #1;
  endtask

  task automatic zero_inputs();
    i_rs1_addr_d = '0; i_rs2_addr_d = '0; i_rs1_addr_e = '0; i_rs2_addr_e = '0;
    i_rd_addr_e = '0; i_result_src_e = 3'b000; i_branch_taken_e = 1'b0;
    i_rd_addr_m = '0; i_reg_we_m = 1'b0; i_rd_addr_w = '0; i_reg_we_w = 1'b0;
    i_mem_access_m = 1'b0; i_mem_ready = 1'b0; i_ecall_m = 1'b0; i_a0_lsb_m = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    i_arst = 1'b1;
    m_reset();
    #1;
    chk({tag, ".rst_halt"}, 32'(o_halt), 32'd0);
    chk({tag, ".rst_exit"}, 32'(o_exit_code), 32'd0);
    chk({tag, ".rst_cnt"},  32'(o_stall_cnt), 32'd0);
    @(posedge i_clk);
    #1;
    i_arst = 1'b0;
  endtask

  // ---------------- combinational vector table ----------------
  typedef struct {
    logic [RW-1:0] rs1_e, rs2_e, rd_m, rd_w, rs1_d, rs2_d, rd_e;
    logic          we_m, we_w, br;
    logic [2:0]    src;
    logic [1:0]    x_f1, x_f2;
    logic          x_sf, x_sd, x_fd, x_fe;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 rs1e rs2e rdm rdw rs1d rs2d rde wem wew br src     f1     f2    sf sd fd fe
    vecs[0] = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 3'b000, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 3'b000, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{5'd3, 5'd9, 5'd9, 5'd3, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 3'b000, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{5'd3, 5'd9, 5'd9, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 3'b001, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd12, 5'd3, 5'd12, 1'b0, 1'b0, 1'b0, 3'b001, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};

    zero_inputs();
    i_arst = 1'b1;
    m_reset();
    @(posedge i_clk);
    apply_reset("init");

    // Table phase: combinational forward / load-use / branch decisions.
    for (int v = 0; v < NV; v++) begin
      i_rs1_addr_e = vecs[v].rs1_e; i_rs2_addr_e = vecs[v].rs2_e;
      i_rd_addr_m = vecs[v].rd_m;   i_reg_we_m = vecs[v].we_m;
      i_rd_addr_w = vecs[v].rd_w;   i_reg_we_w = vecs[v].we_w;
      i_rs1_addr_d = vecs[v].rs1_d; i_rs2_addr_d = vecs[v].rs2_d;
      i_rd_addr_e = vecs[v].rd_e;   i_result_src_e = vecs[v].src;
      i_branch_taken_e = vecs[v].br;
      @(negedge i_clk);
      chk($sformatf("vec%0d.fwd1", v), 32'(o_fwd_rs1_e), 32'(vecs[v].x_f1));
      chk($sformatf("vec%0d.fwd2", v), 32'(o_fwd_rs2_e), 32'(vecs[v].x_f2));
      chk($sformatf("vec%0d.stall_f", v), 32'(o_stall_f), 32'(vecs[v].x_sf));
      chk($sformatf("vec%0d.stall_d", v), 32'(o_stall_d), 32'(vecs[v].x_sd));
      chk($sformatf("vec%0d.flush_d", v), 32'(o_flush_d), 32'(vecs[v].x_fd));
      chk($sformatf("vec%0d.flush_e", v), 32'(o_flush_e), 32'(vecs[v].x_fe));
      @(posedge i_clk);
      #1;
    end

    // Memory wait: 4 stalled cycles, then ready releases in the same cycle.
    zero_inputs();
    apply_reset("memw");
    i_mem_access_m = 1'b1; i_mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) step("memw");
    i_mem_ready = 1'b1;
    #1;
    chk("memw.cnt4", 32'(o_stall_cnt), 32'd4);
    chk("memw.release_m", 32'(o_stall_m), 32'd0);
    chk("memw.release_f", 32'(o_stall_f), 32'd0);
    step("memw_rdy");
    i_mem_access_m = 1'b1; i_mem_ready = 1'b1;  // ready in first cycle: no stall
    step("memw_fast");
    chk("memw.fast_cnt", 32'(o_stall_cnt), 32'd4);

    // ECALL drain to halt with exit bit 1.
    zero_inputs();
    apply_reset("ecall");
    i_ecall_m = 1'b1; i_a0_lsb_m = 1'b1;
    step("ecall_run");
    i_ecall_m = 1'b0; i_a0_lsb_m = 1'b0;
    chk("ecall.drain_sf", 32'(o_stall_f), 32'd1);
    chk("ecall.drain_fe", 32'(o_flush_e), 32'd1);
    step("ecall_drain");
    step("ecall_drain");
    chk("ecall.halt", 32'(o_halt), 32'd1);
    chk("ecall.exit", 32'(o_exit_code), 32'd1);
    for (int k = 0; k < 10; k++) step("ecall_halt");
    chk("ecall.halt_held", 32'(o_halt), 32'd1);

    // ECALL coincident with a memory stall, then reset mid-DRAIN.
    zero_inputs();
    apply_reset("ecmem");
    i_ecall_m = 1'b1; i_mem_access_m = 1'b1; i_mem_ready = 1'b0;
    step("ecmem_stall");
    step("ecmem_wait");
    chk("ecmem.no_drain_yet", 32'(o_stall_e), 32'd1);
    i_mem_ready = 1'b1;
    step("ecmem_ready");
    i_mem_access_m = 1'b0;
    step("ecmem_take");
    i_ecall_m = 1'b0; i_mem_ready = 1'b0;
    step("ecmem_drain");
    chk("ecmem.in_drain", 32'(o_flush_e), 32'd1);
    #2;
    apply_reset("drain_rst");
    chk("drain_rst.stall_f", 32'(o_stall_f), 32'd0);
    step("after_rst");

    // Counter saturation.
    zero_inputs();
    apply_reset("sat");
    i_mem_access_m = 1'b1; i_mem_ready = 1'b0;
    for (int k = 0; k < 20; k++) step("sat");
    chk("sat.cnt15", 32'(o_stall_cnt), 32'd15);

    // Randomized traffic against the model.
    zero_inputs();
    apply_reset("rand");
    for (int k = 0; k < 400; k++) begin
      i_rs1_addr_d = RW'($urandom_range(0, 7)); i_rs2_addr_d = RW'($urandom_range(0, 7));
      i_rs1_addr_e = RW'($urandom_range(0, 7)); i_rs2_addr_e = RW'($urandom_range(0, 7));
      i_rd_addr_e  = RW'($urandom_range(0, 7)); i_result_src_e = 3'($urandom_range(0, 3));
      i_branch_taken_e = ($urandom_range(0, 7) == 0);
      i_rd_addr_m = RW'($urandom_range(0, 7)); i_reg_we_m = 1'($urandom_range(0, 1));
      i_rd_addr_w = RW'($urandom_range(0, 7)); i_reg_we_w = 1'($urandom_range(0, 1));
      i_mem_access_m = ($urandom_range(0, 2) == 0);
      i_mem_ready = 1'($urandom_range(0, 1));
      i_ecall_m = ($urandom_range(0, 19) == 0);
      i_a0_lsb_m = 1'($urandom_range(0, 1));
      step("rand");
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
        apply_reset("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
